// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: shifts out an opcode MSB first, then clocks in
// a run-time selected number of response bytes, framed by chip_select setup/hold.
module spi_cmd_master #(
  parameter int CLK_DIV      = 2,
  parameter int CMD_BITS     = 8,
  parameter int MAX_RX_BYTES = 4,
  parameter int LEN_W        = $clog2(MAX_RX_BYTES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CMD_BITS-1:0]       opcode,
  input  logic [LEN_W-1:0]          rx_len,
  output logic                      busy,
  output logic                      done,
  output logic [8*MAX_RX_BYTES-1:0] rx_data,
  output logic                      SPICLK,
  output logic                      SPIMOSI,
  input  logic                      SPIMISO,
  output logic                      chip_select
);

  localparam int HC_W = $clog2(CLK_DIV + 1);
  localparam int BC_W = $clog2(CMD_BITS + 8*MAX_RX_BYTES + 1);
  localparam int RX_W = 8*MAX_RX_BYTES;
  localparam logic [HC_W-1:0] HC_RLD = HC_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

  state_t            r_state;
  logic [HC_W-1:0]   r_hcnt;
  logic [BC_W-1:0]   r_bcnt;
  logic [CMD_BITS-1:0] r_tx;
  logic [LEN_W-1:0]  r_len;
  logic [RX_W-1:0]   r_rx;
  logic              r_sclk, r_mosi, r_cs, r_busy, r_done;

  logic [LEN_W-1:0]    w_len;
  logic [BC_W-1:0]     w_nbits;
  logic                w_last, w_resp, w_next_cmd;
  logic [CMD_BITS-1:0] w_tx_nxt;

  // Requests longer than the capture register are clamped to its capacity.
  assign w_len      = (rx_len > LEN_W'(MAX_RX_BYTES)) ? LEN_W'(MAX_RX_BYTES) : rx_len;
  assign w_nbits    = BC_W'(CMD_BITS) + (BC_W'(r_len) << 3);
  assign w_last     = (r_bcnt == w_nbits - BC_W'(1));
  assign w_resp     = (r_bcnt >= BC_W'(CMD_BITS));
  assign w_next_cmd = ((r_bcnt + BC_W'(1)) < BC_W'(CMD_BITS));
  assign w_tx_nxt   = r_tx << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
      r_tx    <= '0;
      r_len   <= '0;
      r_rx    <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_SETUP;
            r_tx    <= opcode;
            r_len   <= w_len;
            r_rx    <= '0;
            r_bcnt  <= '0;
            r_hcnt  <= HC_RLD;
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= opcode[CMD_BITS-1];
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SETUP: begin
          if (r_hcnt == '0) begin
            r_state <= S_SHIFT;
            r_hcnt  <= HC_RLD;
            r_mosi  <= r_tx[CMD_BITS-1];
          end else begin
            r_hcnt <= r_hcnt - HC_W'(1);
          end
        end
        S_SHIFT: begin
          if (r_hcnt != '0) begin
            r_hcnt <= r_hcnt - HC_W'(1);
          end else begin
            r_hcnt <= HC_RLD;
            if (!r_sclk) begin
              // Rising edge: capture MISO only once the opcode has gone out.
              r_sclk <= 1'b1;
              if (w_resp) r_rx <= {r_rx[RX_W-2:0], SPIMISO};
            end else begin
              r_sclk <= 1'b0;
              r_bcnt <= r_bcnt + BC_W'(1);
              r_tx   <= w_tx_nxt;
              if (w_last) begin
                r_state <= S_HOLD;
                r_mosi  <= 1'b0;
              end else begin
                r_mosi <= w_next_cmd ? w_tx_nxt[CMD_BITS-1] : 1'b0;
              end
            end
          end
        end
        S_HOLD: begin
          if (r_hcnt == '0) begin
            r_state <= S_DONE;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_hcnt <= r_hcnt - HC_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign rx_data     = r_rx;
  assign SPICLK      = r_sclk;
  assign SPIMOSI     = r_mosi;
  assign chip_select = r_cs;

endmodule

// File: doc/spi_cmd_master.md
# spi_cmd_master

Parametrised SPI mode-0 master for serial flash command transactions. It sends a CMD_BITS-wide opcode, then clocks in a run-time-selected number of response bytes (0..MAX_RX_BYTES). It also provides a programmable SPICLK divider and a start/busy/done handshake to the controlling logic. It sits between the system-side control FSM and the flash pins, and generalises the fixed 0x9F/24-bit RDID engine to any opcode and read length.

## Interface
- CLK_DIV, 2: clk cycles per SPICLK half-period; legal values ≥ 1.
- CMD_BITS, 8: opcode width, shifted MSB first.
- MAX_RX_BYTES, 4: capacity of rx_data in bytes; ≥ 1.
- LEN_W, clog2(MAX_RX_BYTES+1): width of rx_len.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; accepted on a clk edge where start=1 and busy=0.
- opcode  in  CMD_BITS  command; latched on accept.
- rx_len  in  LEN_W  response bytes to read; latched on accept.
- busy  out  1  high while a transaction is in progress.
- done  out  1  one-cycle pulse at the end of a transaction.
- rx_data  out  8*MAX_RX_BYTES  received bytes, right-aligned, last byte in [7:0].
- SPICLK  out  1  serial clock, idles low.
- SPIMOSI  out  1  serial data out.
- SPIMISO  in  1  serial data in.
- chip_select  out  1  active-low flash select.

## Operation
- Outputs after reset: SPICLK=0, SPIMOSI=0, chip_select=1, busy=0, done=0, rx_data=0. All outputs are registered.
- Accept: on the accept edge, latch opcode into the tx shift register and latch L = min(rx_len, MAX_RX_BYTES). Clear rx_data to 0. start is ignored while busy=1.
- N = CMD_BITS + 8*L total bits.
- States:
  - IDLE → CS_SETUP on accept.
  - CS_SETUP (CLK_DIV cycles) → SHIFT.
  - SHIFT (N bits) → CS_HOLD.
  - CS_HOLD (CLK_DIV cycles) → DONE.
  - DONE (1 cycle) → IDLE, or → CS_SETUP if a new start is accepted in DONE.
- CS_SETUP: chip_select=0, SPICLK=0, SPIMOSI=opcode MSB.
- SHIFT: each bit is CLK_DIV cycles of SPICLK=0 followed by CLK_DIV cycles of SPICLK=1.
  - SPIMOSI changes only on the edge where SPICLK goes 1→0, and on entry from CS_SETUP.
  - Opcode bits go out MSB first. SPIMOSI=0 for all response bits.
- Sampling: SPIMISO is sampled on the clk edge where SPICLK goes 0→1, only during the response bits. Each sample is shifted into rx_data LSB, shifting left by one.
- CS_HOLD: SPICLK=0, chip_select=0, SPIMOSI=0.
- DONE: chip_select=1, done=1, busy=0.
- busy=1 in CS_SETUP, SHIFT and CS_HOLD.
- rx_data holds its value from DONE until the next accept.
- L=0 gives a command-only transaction: N=CMD_BITS, and rx_data stays 0.
- Bits of rx_data above 8*L remain 0.
- Asynchronous reset at any point, including mid-bit, forces all reset values immediately and abandons the transaction. No done pulse is produced.

## Timing
- Accept edge = cycle 0. busy=1 and chip_select=0 from cycle 1.
- First SPICLK rise: cycle 1 + 2*CLK_DIV.
- done=1 in cycle CLK_DIV*(2N+2) + 1. busy=0 in that same cycle.
- Exactly N SPICLK rising edges occur per transaction. No glitches occur on SPICLK between transactions.
- Minimum chip_select high time between back-to-back transactions: 1 clk cycle (start held high through DONE).
- A half-period counter of clog2(CLK_DIV+1) bits reloads at every SPICLK toggle. A bit counter of clog2(CMD_BITS+8*MAX_RX_BYTES+1) bits counts the bits.

## Test plan
- RDID: CLK_DIV=2, opcode=0x9F, rx_len=3, slave model drives 0xEF4018 MSB-first on SPICLK falls.
  - MOSI reads 1001_1111; 32 SPICLK rises.
  - done at cycle 133; rx_data=0x00EF4018.
- Command-only: opcode=0x06, rx_len=0.
  - 8 SPICLK rises.
  - done at cycle 37 (CLK_DIV=2); rx_data=0; SPIMOSI=0 after bit 7.
- Start while busy: pulse start with opcode=0x05 at cycle 10 of an RDID transaction.
  - Ignored; MOSI still carries 0x9F; a single done pulse.
- Clamp and divider: CLK_DIV=1, rx_len=7, MAX_RX_BYTES=4.
  - 40 SPICLK rises; all 4 bytes captured.
  - done at cycle 83.
- Back-to-back: start held high.
  - chip_select high for exactly 1 cycle (the DONE cycle).
  - The second transaction begins with chip_select=0 the next cycle.
- Reset mid-transaction: assert reset mid-SHIFT, asynchronously between clk edges.
  - chip_select=1, SPICLK=0, busy=0 immediately; no done pulse.
  - The next start runs a normal transaction.
